// File: rtl/alu_seq_shifter.sv
// alu_seq_shifter: multi-cycle shift/rotate unit sitting beside the ALU.
// Supports SLL, SRL, SRA, ROL and ROR, shifting up to STEP bits per cycle,
// with a start/busy/done handshake and overflow (OV) / zero (ZF) flags.
// Optional feature macro: ALU_SHIFT_SAT_EN adds OP 101 = SLS, a saturating
// left shift. When the macro is undefined, OP 101 behaves as a reserved code.
module alu_seq_shifter #(
  parameter int NIO  = 8,
  parameter int STEP = 1,
  parameter int SW   = $clog2(NIO) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [NIO-1:0] A,
  input  logic [SW-1:0]  B,
  input  logic [2:0]     OP,
  output logic [NIO-1:0] Z,
  output logic           OV,
  output logic           ZF,
  output logic           busy,
  output logic           done
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
`ifdef ALU_SHIFT_SAT_EN
  localparam logic [2:0] OP_SLS = 3'b101;
`endif

  localparam logic [SW-1:0] NIO_W  = SW'(NIO);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [NIO-1:0] work;
  logic [2:0]     op_r;
  logic [SW-1:0]  cnt;
  logic           acc;
`ifdef ALU_SHIFT_SAT_EN
  logic           sign_r;
`endif

  logic [SW-1:0]         eff;
  logic [SW-1:0]         clamp;
  logic [SW-1:0]         k;
  logic [NIO-1:0]        shl;
  logic signed [NIO-1:0] back;
  logic [NIO-1:0]        next_work;
  logic                  ov_step;
  logic [NIO-1:0]        z_final;

  // Effective shift amount for the operation being requested.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    eff   = '0;
    clamp = (B > NIO_W) ? NIO_W : B;
    case (OP)
      OP_SLL, OP_SRL, OP_SRA: eff = clamp;
`ifdef ALU_SHIFT_SAT_EN
      OP_SLS:                 eff = clamp;
`endif
      OP_ROL, OP_ROR:         eff = {1'b0, B[SW-2:0]};  // B mod NIO, NIO is a power of 2
      default:                eff = '0;                 // reserved: pass A through
    endcase
  end

  // One iteration step: shift work by k = min(STEP, cnt) and detect lost sign bits.
  always_comb begin
    k         = (cnt < STEP_W) ? cnt : STEP_W;
    shl       = work << k;
    // Shifting back arithmetically recovers work only if the top k+1 bits were equal.
    back      = $signed(shl) >>> k;
    next_work = work;
    ov_step   = 1'b0;
    case (op_r)
      OP_SLL: begin
        next_work = shl;
        ov_step   = (back != $signed(work));
      end
`ifdef ALU_SHIFT_SAT_EN
      OP_SLS: begin
        next_work = shl;
        ov_step   = (back != $signed(work));
      end
`endif
      OP_SRL:  next_work = work >> k;
      OP_SRA:  next_work = $signed(work) >>> k;
      OP_ROL:  next_work = shl | (work >> (NIO_W - k));
      OP_ROR:  next_work = (work >> k) | (work << (NIO_W - k));
      default: next_work = work;
    endcase
  end

  // Final result, with saturation applied when the optional feature is built in.
  always_comb begin
    z_final = work;
`ifdef ALU_SHIFT_SAT_EN
    if (op_r == OP_SLS && acc) begin
      z_final = sign_r ? {1'b1, {(NIO-1){1'b0}}} : {1'b0, {(NIO-1){1'b1}}};
    end
`endif
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the working registers are reset too; they are few and it keeps the
    // datapath deterministic after a mid-operation abort.
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      op_r  <= '0;
      cnt   <= '0;
      acc   <= 1'b0;
`ifdef ALU_SHIFT_SAT_EN
      sign_r <= 1'b0;
`endif
      Z     <= '0;
      OV    <= 1'b0;
      ZF    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= A;
            op_r  <= OP;
            cnt   <= eff;
            acc   <= 1'b0;
`ifdef ALU_SHIFT_SAT_EN
            sign_r <= A[NIO-1];
`endif
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            Z     <= z_final;
            OV    <= acc;
            ZF    <= (z_final == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            work <= next_work;
            cnt  <= cnt - k;
            acc  <= acc | ov_step;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_shifter.sv
// Testbench for alu_seq_shifter: a STEP=1 and a STEP=3 instance (NIO=8),
// scoreboard of expected results computed from an arithmetic model.
module tb_alu_seq_shifter;

  localparam logic [2:0] SLL = 3'b000;
  localparam logic [2:0] SRL = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROL = 3'b011;
  localparam logic [2:0] ROR = 3'b100;
  localparam logic [2:0] SLS = 3'b101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic [7:0] a1 = '0, a3 = '0;
  logic [3:0] b1 = '0, b3 = '0;
  logic [2:0] op1 = '0, op3 = '0;
  logic [7:0] z1, z3;
  logic       ov1, ov3, zf1, zf3, busy1, busy3, done1, done3;

  always #5 clk = ~clk;

  alu_seq_shifter #(.NIO(8), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .OP(op1),
    .Z(z1), .OV(ov1), .ZF(zf1), .busy(busy1), .done(done1)
  );

  alu_seq_shifter #(.NIO(8), .STEP(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3), .OP(op3),
    .Z(z3), .OV(ov3), .ZF(zf3), .busy(busy3), .done(done3)
  );

  typedef struct {
    logic [7:0] z;
    logic       ov;
    logic       zf;
    int         lat;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       sel3 = 1'b0;
  logic [7:0] last_z [2];

  logic [7:0] obs_z;
  logic       obs_ov, obs_zf, obs_busy, obs_done;
  always_comb begin
    obs_z    = sel3 ? z3    : z1;
    obs_ov   = sel3 ? ov3   : ov1;
    obs_zf   = sel3 ? zf3   : zf1;
    obs_busy = sel3 ? busy3 : busy1;
    obs_done = sel3 ? done3 : done1;
  end

  // Reference model: arithmetic meaning of each operation, latency in edges after start.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a,
                                 input logic [3:0] b, input int step);
    exp_t       e;
    int         eff, clamp, sa, v;
    logic [7:0] r;
    clamp = (int'(b) > 8) ? 8 : int'(b);
    sa    = int'($signed(a));
    eff   = 0;
    r     = a;
    e.ov  = 1'b0;
    case (op)
      SLL: begin
        eff  = clamp;
        v    = sa * (1 << eff);
        r    = v[7:0];
        e.ov = (v > 127) || (v < -128);
      end
      SRL: begin eff = clamp; r = a >> eff; end
      SRA: begin eff = clamp; r = $signed(a) >>> eff; end
      ROL: begin
        eff = int'(b) % 8;
        repeat (eff) r = {r[6:0], r[7]};
      end
      ROR: begin
        eff = int'(b) % 8;
        repeat (eff) r = {r[0], r[7:1]};
      end
      SLS: begin
`ifdef ALU_SHIFT_SAT_EN
        eff  = clamp;
        v    = sa * (1 << eff);
        r    = v[7:0];
        e.ov = (v > 127) || (v < -128);
        if (e.ov) r = a[7] ? 8'h80 : 8'h7F;
`endif
      end
      default: ;
    endcase
    e.z   = r;
    e.zf  = (r == 8'h00);
    e.lat = (eff + step - 1) / step + 1;
    return e;
  endfunction

  // Drive a request now; the next rising edge is the start edge. Returns #1 after it.
  task automatic launch_now(input logic s, input logic [2:0] op, input logic [7:0] a,
                            input logic [3:0] b);
    sel3 = s;
    if (s) begin op3 = op; a3 = a; b3 = b; start3 = 1'b1; end
    else   begin op1 = op; a1 = a; b1 = b; start1 = 1'b1; end
    sb_q.push_back(model(op, a, b, s ? 3 : 1));
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic launch(input logic s, input logic [2:0] op, input logic [7:0] a,
                        input logic [3:0] b);
    @(negedge clk);
    launch_now(s, op, a, b);
  endtask

  // Wait (bounded) for done, pop the scoreboard and compare; optionally pulse
  // start with junk operands 'poke' cycles into the operation.
  task automatic collect(input string name, input int poke);
    exp_t e;
    int   lat = 0;
    int   idx = sel3 ? 1 : 0;
    logic busy_bad = (obs_busy !== 1'b1);
    logic hold_bad = (obs_z !== last_z[idx]);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      start3 = 1'b0;
      if (obs_done === 1'b1) begin lat = i; break; end
      if (obs_busy !== 1'b1) busy_bad = 1'b1;
      if (obs_z !== last_z[idx]) hold_bad = 1'b1;
      if (i == poke) begin
        if (sel3) begin a3 = 8'h5A; b3 = 4'd3; op3 = ROL; start3 = 1'b1; end
        else      begin a1 = 8'h5A; b1 = 4'd3; op1 = ROL; start1 = 1'b1; end
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: done seen with empty scoreboard", name);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (obs_z !== e.z) begin errors++; $display("FAIL %s Z: got %h want %h", name, obs_z, e.z); end
    checks++;
    if (obs_ov !== e.ov) begin errors++; $display("FAIL %s OV: got %b want %b", name, obs_ov, e.ov); end
    checks++;
    if (obs_zf !== e.zf) begin errors++; $display("FAIL %s ZF: got %b want %b", name, obs_zf, e.zf); end
    checks++;
    if (lat != e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat); end
    checks++;
    if (busy_bad !== 1'b0) begin errors++; $display("FAIL %s busy: dropped before done", name); end
    checks++;
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL %s busy at done: got %b want 0", name, obs_busy); end
    checks++;
    if (hold_bad !== 1'b0) begin errors++; $display("FAIL %s Z hold: changed before done, last %h", name, last_z[idx]); end
    last_z[idx] = e.z;
  endtask

  // No done pulse and no busy on either instance for n cycles.
  task automatic expect_quiet(input string name, input int n);
    logic bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done1 !== 1'b0 || done3 !== 1'b0 || busy1 !== 1'b0 || busy3 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL %s: unexpected done/busy while idle", name); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (z1 !== 8'h00)   begin errors++; $display("FAIL reset Z: got %h want 00", z1); end
    checks++; if (ov1 !== 1'b0)   begin errors++; $display("FAIL reset OV: got %b want 0", ov1); end
    checks++; if (zf1 !== 1'b0)   begin errors++; $display("FAIL reset ZF: got %b want 0", zf1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done1); end
    last_z[0] = 8'h00;
    last_z[1] = 8'h00;
  endtask

  task automatic test_sra();
    launch(1'b0, SRA, 8'b1001_0110, 4'd3); collect("sra_neg_b3", 0);
    launch(1'b0, SRA, 8'h7C, 4'd2);        collect("sra_pos_b2", 0);
    launch(1'b0, SRA, 8'h81, 4'd12);       collect("sra_clamp", 0);
  endtask

  task automatic test_sll();
    launch(1'b0, SLL, 8'h40, 4'd1); collect("sll_40_b1", 0);
    launch(1'b0, SLL, 8'h03, 4'd2); collect("sll_03_b2", 0);
    launch(1'b0, SLL, 8'hFF, 4'd8); collect("sll_ff_b8", 0);
    launch(1'b0, SLL, 8'hF0, 4'd3); collect("sll_f0_b3", 0);
  endtask

  task automatic test_rotate_srl();
    launch(1'b0, ROR, 8'b1000_0001, 4'd9); collect("ror_b9", 0);
    launch(1'b0, ROL, 8'hB4, 4'd3);        collect("rol_b3", 0);
    launch(1'b0, SRL, 8'h96, 4'd2);        collect("srl_b2", 0);
  endtask

  task automatic test_reserved();
    launch(1'b0, 3'b110, 8'hA5, 4'd5); collect("rsv_110", 0);
    launch(1'b0, 3'b111, 8'h3C, 4'd1); collect("rsv_111", 0);
    launch(1'b0, SLS, 8'h30, 4'd2);    collect("op101_30", 0);
    launch(1'b0, SLS, 8'hD0, 4'd2);    collect("op101_d0", 0);
    launch(1'b0, SLS, 8'h05, 4'd2);    collect("op101_05", 0);
  endtask

  task automatic test_ignore_start();
    launch(1'b0, SRL, 8'hFF, 4'd15);
    collect("srl_clamp_ignore", 2);
    expect_quiet("ignore_no_extra_op", 12);
  endtask

  task automatic test_back_to_back();
    launch(1'b0, SLL, 8'h03, 4'd2);
    collect("b2b_first", 0);
    launch_now(1'b0, SRA, 8'b1001_0110, 4'd3);
    collect("b2b_second", 0);
  endtask

  task automatic test_async_reset();
    launch(1'b0, ROL, 8'h0F, 4'd1); collect("pre_reset", 0);
    launch(1'b0, SRL, 8'h80, 4'd8);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (z1 !== 8'h00)   begin errors++; $display("FAIL async_rst Z: got %h want 00", z1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL async_rst busy: got %b want 0", busy1); end
    checks++; if ({ov1, zf1, done1} !== 3'b000) begin errors++; $display("FAIL async_rst flags: got %b want 000", {ov1, zf1, done1}); end
    sb_q.delete();
    last_z[0] = 8'h00;
    last_z[1] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("after_reset_idle", 12);
    launch(1'b0, ROR, 8'h06, 4'd1); collect("post_reset_op", 0);
  endtask

  task automatic test_step3();
    launch(1'b1, SLL, 8'h01, 4'd7);  collect("s3_sll_01_b7", 0);
    launch(1'b1, SRA, 8'h80, 4'd8);  collect("s3_sra_b8", 0);
    launch(1'b1, ROL, 8'h81, 4'd5);  collect("s3_rol_b5", 0);
    launch(1'b1, SRL, 8'hC3, 4'd3);  collect("s3_srl_b3", 0);
    launch(1'b1, SLS, 8'h30, 4'd2);  collect("s3_op101", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sra();
    test_sll();
    test_rotate_srl();
    test_reserved();
    test_ignore_start();
    test_back_to_back();
    test_step3();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_shifter.md
Name: alu_seq_shifter

Overview:
- Parametrised multi-cycle shift/rotate unit; successor to the single-cycle ALU shift-right operation.
- Widens the shift set to logical, arithmetic and rotate in both directions, with a configurable bits-per-cycle step.
- Uses a start/busy/done handshake and reports overflow (OV) and zero (ZF) flags.
- Sits beside the ALU as its shift execution resource; operands use the ALU's A/B/OP/Z/OV naming.

Parameters:
- NIO, 8: data width; power of 2, at least 4.
- STEP, 1: maximum bits shifted per cycle; 1..NIO.
- SW, $clog2(NIO)+1: shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  NIO  signed operand.
- B  in  SW  unsigned shift amount.
- OP  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101 SLS (feature only), 110/111 reserved.
- Z  out  NIO  result; holds until the next completion.
- OV  out  1  signed overflow (SLL/SLS only).
- ZF  out  1  Z == 0.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; Z=0, OV=0, ZF=0, busy=0, done=0. Any in-flight operation is dropped.
- States: IDLE, SHIFT.
- IDLE, edge with start=1:
  - Capture A into work, OP into op_r, effective amount into cnt; clear the OV accumulator.
  - busy<=1; go to SHIFT.
  - done<=0 on every edge that does not complete an operation.
- Effective amount:
  - SLL/SRL/SRA/SLS: min(B, NIO).
  - ROL/ROR: B mod NIO.
  - Reserved OP: 0.
- SHIFT, edge with cnt==0:
  - Z<=work, OV<=accumulator, ZF<=(work==0), done<=1, busy<=0; go to IDLE.
- SHIFT, edge with cnt!=0:
  - k=min(STEP, cnt); shift work by k; cnt<=cnt-k.
  - SLL only: accumulator |= (top k+1 bits of work before the shift are not all equal).
- Fill rules: SLL zero-fills LSBs; SRL zero-fills MSBs; SRA replicates the sign bit; rotates wrap.
- Latency: done is high in the cycle after edge e0+ceil(eff/STEP)+1, where e0 is the start edge. Minimum is 1 edge after e0 (eff=0).
- Start in SHIFT is ignored; A/B/OP changes during SHIFT have no effect.
- Start in the cycle done is high (state IDLE) is accepted: back-to-back operations allowed.
- Reserved OP: Z=A, OV=0, completes at minimum latency.
- SLL with eff=NIO: Z=0; OV=1 iff A!=0 (falls out of the accumulator rule).
- OV=0 for all ops other than SLL/SLS.

Optional Feature:
- Macro ALU_SHIFT_SAT_EN.
- Defined: OP 101 = SLS, a saturating left shift. Same iteration and OV accumulation as SLL. At completion, if OV=1 then Z = 0111..1 when A[NIO-1]=0, else 1000..0. ZF evaluates on the final Z.
- Undefined: OP 101 is reserved (Z=A, OV=0, minimum latency); no saturation logic synthesised.

Test Plan:
- NIO=8, STEP=1; SRA A=8'b1001_0110 (-106), B=3 -> Z=8'b1111_0010 (-14), OV=0, ZF=0; done 4 edges after start edge; busy high for the 4 intervening cycles.
- SLL A=8'h40, B=1 -> Z=8'h80, OV=1. SLL A=8'h03, B=2 -> Z=8'h0C, OV=0. SLL A=8'hFF, B=8 -> Z=0, OV=1, ZF=1.
- ROR A=8'b1000_0001, B=9 -> eff 1 -> Z=8'b1100_0000, done 2 edges after start. SRL A=8'hFF, B=15 -> clamp 8 -> Z=0, ZF=1, done 9 edges after start.
- Handshake:
  - Start pulsed while busy -> ignored, Z unchanged.
  - Start on the done cycle -> second op accepted, first Z retained until second completes.
  - rst asserted mid-SHIFT -> all outputs 0 immediately (asynchronous), state IDLE.
- NIO=8, STEP=3; SLL A=8'h01, B=7 -> Z=8'h80, OV=1; done 4 edges after start (3 shift edges + completion).
- With ALU_SHIFT_SAT_EN: OP=101, A=8'h30, B=2 -> Z=8'h7F, OV=1; A=8'hD0, B=2 -> Z=8'h80, OV=1. Without the macro: same stimulus -> Z=A, OV=0, done 1 edge after start.
